event_collector: RTL and testbench

Fan-in counterpart of the event dispatch path. Collects single-cycle event pulses from `SRC_COUNT` hardware sources, counts outstanding occurrences per source, and serialises them round-robin onto one valid/ready event-number stream. Each source has a CSR-programmable event number. The output feeds the event router's event-source input, so routing is unchanged downstream.

---
 rtl/event_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/event_collector.sv | 171 +++++++++++++++++
 tb/tb_event_collector.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared definitions for the event collector: CSR field layout, command codes
// and a constant-width helper.
package event_pkg;

  // Configuration command codes carried in the top nibble of the CSR word
  localparam logic [3:0] CMD_MAP   = 4'd0;
  localparam logic [3:0] CMD_CLEAR = 4'd1;

  // Configuration word field positions (source index always starts at bit 0)
  localparam int CSR_EVNO_LSB   = 8;
  localparam int CSR_ENABLE_BIT = 16;
  localparam int CSR_CMD_LSB    = 28;
  localparam int CSR_CMD_W      = 4;

  // Ceiling log2; returns 0 for values of 1 or less
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request found while
// scanning upward (with wrap) from ptr wins.
module rr_arbiter
  import event_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan all N positions starting at ptr and latch the first requester
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/event_collector.sv
// Event collector: counts event pulses per source, and hands the pending
// occurrences round-robin to a single valid/ready stream of mapped event
// numbers. Each source carries a CSR-programmable event number and enable.
module event_collector
  import event_pkg::*;
#(
  parameter int SRC_COUNT  = 8,
  parameter int SRC_BITS   = 3,
  parameter int COUNT_BITS = 4,
  parameter int PEND_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           s_cer_data,
  input  logic                  s_cer_valid,
  output logic                  s_cer_ready,
  input  logic [SRC_COUNT-1:0]  src_event,
  output logic [COUNT_BITS-1:0] m_evno_data,
  output logic                  m_evno_valid,
  input  logic                  m_evno_ready,
  output logic [SRC_COUNT-1:0]  ovf_status
);

  localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

  // Decoded configuration word
  logic [CSR_CMD_W-1:0]  cfg_cmd;
  logic [SRC_BITS-1:0]   cfg_idx;
  logic [COUNT_BITS-1:0] cfg_evno;
  logic                  cfg_en;
  logic                  cfg_map;
  logic                  cfg_clear;
  logic                  cfg_unused;

  // Arbitration
  logic [SRC_COUNT-1:0]                 req;
  logic [SRC_COUNT-1:0]                 grant;
  logic [SRC_BITS-1:0]                  grant_idx;
  logic                                 grant_any;
  logic                                 out_free;
  logic                                 do_grant;
  logic [SRC_COUNT-1:0][COUNT_BITS-1:0] map_all;

  // Output register and round-robin pointer
  logic [SRC_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [COUNT_BITS-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  assign s_cer_ready = 1'b1;

  assign cfg_cmd   = s_cer_data[CSR_CMD_LSB +: CSR_CMD_W];
  assign cfg_idx   = s_cer_data[SRC_BITS-1:0];
  assign cfg_evno  = s_cer_data[CSR_EVNO_LSB +: COUNT_BITS];
  assign cfg_en    = s_cer_data[CSR_ENABLE_BIT];
  assign cfg_map   = (cfg_cmd == CMD_MAP);
  assign cfg_clear = (cfg_cmd == CMD_CLEAR);
  // Reserved bits of the configuration word are deliberately ignored
  assign cfg_unused = ^s_cer_data;

  // The output register can take a new event when empty or being drained
  assign out_free = !out_valid_q || m_evno_ready;
  assign do_grant = grant_any && out_free;

  for (genvar gi = 0; gi < SRC_COUNT; gi++) begin : gen_src
    logic [COUNT_BITS-1:0] map_q, map_d;
    logic                  en_q, en_d;
    logic [PEND_BITS-1:0]  pend_q, pend_d;
    logic                  ovf_q, ovf_d;
    logic                  hit;
    logic                  map_we;
    logic                  clr_we;
    logic                  inc;
    logic                  dec;
    logic                  sat;

    // An index beyond the source count never matches any slot
    assign hit    = (cfg_idx == SRC_BITS'(gi));
    assign map_we = s_cer_valid && cfg_map && hit;
    assign clr_we = s_cer_valid && cfg_clear && hit;
    // Pulses to a disabled source are dropped here, before they can count
    assign inc    = src_event[gi] && en_q;
    assign dec    = do_grant && grant[gi];
    assign sat    = (pend_q == PEND_MAX);

    // Next mapping/enable plus pending count; CLEAR overrides a same-cycle grant
    always_comb begin
      map_d  = map_q;
      en_d   = en_q;
      pend_d = pend_q;
      ovf_d  = ovf_q;
      if (map_we) begin
        map_d = cfg_evno;
        en_d  = cfg_en;
      end
      if (clr_we) begin
        pend_d = '0;
        ovf_d  = 1'b0;
      end else if (inc && !dec) begin
        if (sat) begin
          ovf_d = 1'b1;
        end else begin
          pend_d = pend_q + PEND_BITS'(1);
        end
      end else if (dec && !inc) begin
        pend_d = pend_q - PEND_BITS'(1);
      end
    end

    // Per-source state; after reset every source is enabled and maps to its own index
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        map_q  <= COUNT_BITS'(gi);
        en_q   <= 1'b1;
        pend_q <= '0;
        ovf_q  <= 1'b0;
      end else begin
        map_q  <= map_d;
        en_q   <= en_d;
        pend_q <= pend_d;
        ovf_q  <= ovf_d;
      end
    end

    assign req[gi]        = en_q && (pend_q != '0);
    assign ovf_status[gi] = ovf_q;
    assign map_all[gi]    = map_q;
  end

  rr_arbiter #(
    .N     (SRC_COUNT),
    .IDX_W (SRC_BITS)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // Load the granted source's current mapping, or empty the register after a handshake
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (do_grant) begin
      out_valid_d = 1'b1;
      out_data_d  = map_all[grant_idx];
      rr_ptr_d    = (grant_idx == SRC_BITS'(SRC_COUNT - 1)) ? '0
                                                          : grant_idx + SRC_BITS'(1);
    end else if (m_evno_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign m_evno_valid = out_valid_q;
  assign m_evno_data  = out_data_q;

endmodule

// File: tb/tb_event_collector.sv
// Self-checking bench for event_collector: a per-cycle vector table, hand
// sequences for overflow, fairness, disable and mid-transfer reset, then a
// randomized run against a behavioural model.
module tb_event_collector;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg_data = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [N-1:0] src_event = '0;
  logic [3:0]  evno_data;
  logic        evno_valid;
  logic        ready = 1'b0;
  logic [N-1:0] ovf;

  int checks = 0;
  int errors = 0;

  event_collector #(
    .SRC_COUNT  (8),
    .SRC_BITS   (3),
    .COUNT_BITS (4),
    .PEND_BITS  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_cer_data   (cfg_data),
    .s_cer_valid  (cfg_valid),
    .s_cer_ready  (cfg_ready),
    .src_event    (src_event),
    .m_evno_data  (evno_data),
    .m_evno_valid (evno_valid),
    .m_evno_ready (ready),
    .ovf_status   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural reference model ----------------
  int   m_pend [N];
  bit   m_en   [N];
  int   m_map  [N];
  bit   m_ovf  [N];
  int   m_ptr;
  bit   m_v;
  int   m_d;
  int   m_in;
  int   m_drops;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0;
      m_en[i]   = 1'b1;
      m_map[i]  = i % 16;
      m_ovf[i]  = 1'b0;
    end
    m_ptr = 0; m_v = 1'b0; m_d = 0; m_in = 0; m_drops = 0;
  endtask

  function automatic logic [N-1:0] model_ovf_vec();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (m_ovf[i]) v = v | (N'(1) << i);
    return v;
  endfunction

  // One clock of the event-collection rules, applied to the model state
  task automatic model_step(input logic cv, input logic [31:0] cd,
                            input logic [7:0] ev, input logic rdy);
    int g;
    int s;
    int cmd;
    int idx;
    bit inc;
    bit dec;
    g = -1;
    if (!m_v || rdy) begin
      for (int k = 0; k < N; k++) begin
        s = (m_ptr + k) % N;
        if (g < 0 && m_en[s] && m_pend[s] > 0) g = s;
      end
    end
    cmd = int'(cd[31:28]);
    idx = int'(cd[2:0]);
    for (int i = 0; i < N; i++) begin
      inc = bit'(ev >> i) && m_en[i];
      dec = (i == g);
      if (inc) m_in++;
      if (cv && cmd == 1 && idx == i) begin
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
      end else if (inc && !dec) begin
        if (m_pend[i] == 15) begin
          m_ovf[i] = 1'b1;
          m_drops++;
        end else begin
          m_pend[i]++;
        end
      end else if (dec && !inc) begin
        m_pend[i]--;
      end
    end
    if (g >= 0) begin
      m_d   = m_map[g];
      m_v   = 1'b1;
      m_ptr = (g + 1) % N;
    end else if (rdy) begin
      m_v = 1'b0;
    end
    if (cv && cmd == 0) begin
      m_map[idx] = int'(cd[11:8]);
      m_en[idx]  = cd[16];
    end
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic cv, input logic [31:0] cd,
                      input logic [7:0] ev, input logic rdy);
    cfg_valid = cv; cfg_data = cd; src_event = ev; ready = rdy;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0; src_event = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; src_event = '0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(evno_valid), 32'd0);
    check("reset_data", 32'(evno_data), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("cer_ready", 32'(cfg_ready), 32'd1);
    $display("reset: valid=%0b data=%0h ovf=%0h", evno_valid, evno_data, ovf);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        cv;
    logic [31:0] cd;
    logic [7:0]  ev;
    logic        rdy;
    logic        x_valid;
    logic [3:0]  x_data;
    logic [7:0]  x_ovf;
  } vec_t;

  vec_t tbl [10];
  int   got [$];
  int   n0, n1, nother, nv, dut_out;
  bit   prev_stall;
  logic [3:0] prev_d;

  initial begin
    // pulses on 2 and 5 together, then MAP 3->0xA and CLEAR 3 while its event is held
    tbl[0] = '{1'b0, 32'h0,         8'h24, 1'b1, 1'b0, 4'h0, 8'h00};
    tbl[1] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 4'h2, 8'h00};
    tbl[2] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b1, 4'h5, 8'h00};
    tbl[3] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 4'h0, 8'h00};
    tbl[4] = '{1'b1, 32'h0001_0A03, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00};
    tbl[5] = '{1'b0, 32'h0,         8'h08, 1'b0, 1'b0, 4'h0, 8'h00};
    tbl[6] = '{1'b0, 32'h0,         8'h08, 1'b0, 1'b1, 4'hA, 8'h00};
    tbl[7] = '{1'b1, 32'h1000_0003, 8'h00, 1'b0, 1'b1, 4'hA, 8'h00};
    tbl[8] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 4'h0, 8'h00};
    tbl[9] = '{1'b0, 32'h0,         8'h00, 1'b1, 1'b0, 4'h0, 8'h00};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].cv, tbl[i].cd, tbl[i].ev, tbl[i].rdy);
      check($sformatf("row%0d_valid", i), 32'(evno_valid), 32'(tbl[i].x_valid));
      if (tbl[i].x_valid)
        check($sformatf("row%0d_data", i), 32'(evno_data), 32'(tbl[i].x_data));
      check($sformatf("row%0d_ovf", i), 32'(ovf), 32'(tbl[i].x_ovf));
      $display("row %0d: valid=%0b data=%0h ovf=%0h", i, evno_valid, evno_data, ovf);
    end

    // ---- saturation: output held by source 0, 20 pulses on source 1 ----
    do_reset();
    step(1'b0, 32'h0, 8'h01, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0);
    check("ovf_hold_valid", 32'(evno_valid), 32'd1);
    check("ovf_hold_data", 32'(evno_data), 32'd0);
    repeat (20) step(1'b0, 32'h0, 8'h02, 1'b0);
    check("ovf_set", 32'(ovf), 32'h02);
    n0 = 0; n1 = 0; nother = 0;
    for (int c = 0; c < 40; c++) begin
      if (evno_valid) begin
        if (evno_data == 4'd0) n0++;
        else if (evno_data == 4'd1) n1++;
        else nother++;
        $display("ovf drain: event number=%0h", evno_data);
      end
      step(1'b0, 32'h0, 8'h00, 1'b1);
    end
    check("ovf_src0_count", 32'(n0), 32'd1);
    check("ovf_src1_count", 32'(n1), 32'd15);
    check("ovf_other_count", 32'(nother), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'h02);
    step(1'b1, 32'h1000_0001, 8'h00, 1'b1);
    check("ovf_cleared", 32'(ovf), 32'h00);

    // ---- fairness: every source pending twice ----
    do_reset();
    step(1'b0, 32'h0, 8'hFF, 1'b1);
    step(1'b0, 32'h0, 8'hFF, 1'b1);
    got.delete();
    for (int c = 0; c < 30; c++) begin
      if (evno_valid) begin
        got.push_back(int'(evno_data));
        $display("fair: event number=%0h", evno_data);
      end
      step(1'b0, 32'h0, 8'h00, 1'b1);
    end
    check("fair_count", 32'(got.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      if (k < got.size()) check($sformatf("fair_order%0d", k), 32'(got[k]), 32'(k % 8));

    // ---- disabled source drops pulses, re-enable resumes ----
    do_reset();
    step(1'b1, 32'h0000_0404, 8'h00, 1'b1);
    repeat (3) step(1'b0, 32'h0, 8'h10, 1'b1);
    step(1'b1, 32'h0001_0404, 8'h00, 1'b1);
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (evno_valid) nv++;
      step(1'b0, 32'h0, 8'h00, 1'b1);
    end
    check("dis_no_events", 32'(nv), 32'd0);
    check("dis_no_ovf", 32'(ovf), 32'd0);
    step(1'b0, 32'h0, 8'h10, 1'b1);
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      if (evno_valid) begin
        nv++;
        check("reen_data", 32'(evno_data), 32'd4);
        $display("reenable: event number=%0h", evno_data);
      end
      step(1'b0, 32'h0, 8'h00, 1'b1);
    end
    check("reen_count", 32'(nv), 32'd1);

    // ---- asynchronous reset while an event is held ----
    do_reset();
    step(1'b0, 32'h0, 8'h40, 1'b0);
    step(1'b0, 32'h0, 8'h40, 1'b0);
    check("mid_held_valid", 32'(evno_valid), 32'd1);
    check("mid_held_data", 32'(evno_data), 32'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_async_valid", 32'(evno_valid), 32'd0);
    check("mid_async_data", 32'(evno_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 32'h0, 8'h00, 1'b1);
      if (evno_valid) nv++;
    end
    check("mid_discarded", 32'(nv), 32'd0);

    // ---- random traffic against the model ----
    do_reset();
    dut_out = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int c = 0; c < 1500; c++) begin
      logic        cv, rdy;
      logic [31:0] cd;
      logic [7:0]  ev;
      int          cmd;
      ev  = 8'($urandom) & 8'($urandom);
      rdy = ($urandom_range(0, 2) != 0);
      cv  = ($urandom_range(0, 19) == 0);
      cmd = $urandom_range(0, 15);
      if (cmd == 1) cmd = 0;
      cd  = {4'(cmd), 11'($urandom), 1'($urandom_range(0, 3) != 0),
             8'($urandom), 5'($urandom), 3'($urandom)};
      if (prev_stall) begin
        check("stall_valid", 32'(evno_valid), 32'd1);
        check("stall_data", 32'(evno_data), 32'(prev_d));
      end
      if (evno_valid && rdy) begin
        dut_out++;
        $display("rand evt %0d: number=%0h", dut_out, evno_data);
      end
      prev_stall = evno_valid && !rdy;
      prev_d = evno_data;
      model_step(cv, cd, ev, rdy);
      step(cv, cd, ev, rdy);
      check("rand_valid", 32'(evno_valid), 32'(m_v));
      if (m_v) check("rand_data", 32'(evno_data), 32'(m_d));
      check("rand_ovf", 32'(ovf), 32'(model_ovf_vec()));
    end
    // re-enable everything with its current number, then drain
    for (int s = 0; s < N; s++) begin
      logic [31:0] cd;
      cd = {4'd0, 11'd0, 1'b1, 4'd0, 4'(m_map[s]), 5'd0, 3'(s)};
      if (evno_valid) dut_out++;
      model_step(1'b1, cd, 8'h00, 1'b1);
      step(1'b1, cd, 8'h00, 1'b1);
      check("en_valid", 32'(evno_valid), 32'(m_v));
      if (m_v) check("en_data", 32'(evno_data), 32'(m_d));
    end
    for (int c = 0; c < 150; c++) begin
      if (evno_valid) dut_out++;
      model_step(1'b0, 32'h0, 8'h00, 1'b1);
      step(1'b0, 32'h0, 8'h00, 1'b1);
      check("drain_valid", 32'(evno_valid), 32'(m_v));
      if (m_v) check("drain_data", 32'(evno_data), 32'(m_d));
    end
    check("drain_empty", 32'(evno_valid), 32'd0);
    check("conservation", 32'(dut_out), 32'(m_in - m_drops));
    $display("random: in=%0d dropped=%0d out=%0d", m_in, m_drops, dut_out);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
